// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared types for the iterative multiply/divide unit
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MDU_MULT,
    MDU_MULTU,
    MDU_DIV,
    MDU_DIVU
  } Mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_FIX,
    MDU_DONE
  } Mdu_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider for the EX stage
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  Mdu_op_t          op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             cancel_i,
  output logic             stallreq_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  Mdu_state_t         state, state_next;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   operand_q;   // multiplicand for MULT, divisor for DIV
  logic [2*WIDTH-1:0] acc;         // {hi, lo}: product or {remainder, quotient}
  logic               is_div;
  logic               res_neg;
  logic               rem_neg;

  logic               accept;
  logic               op_div;
  logic               op_signed;
  logic               a_sign;
  logic               b_sign;
  logic               div_zero;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;

  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     add_y;
  logic               add_sub;
  logic [WIDTH+1:0]   add_sum;
  logic [2*WIDTH-1:0] acc_step;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign accept    = (state == MDU_IDLE) && start_i && !cancel_i;
  assign op_div    = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
  assign op_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
  assign a_sign    = op_signed && opa_i[WIDTH-1];
  assign b_sign    = op_signed && opb_i[WIDTH-1];
  assign a_abs     = a_sign ? (WIDTH'(0) - opa_i) : opa_i;
  assign b_abs     = b_sign ? (WIDTH'(0) - opb_i) : opb_i;
  assign div_zero  = op_div && (opb_i == '0);

  // Shared iteration adder: add the multiplicand, or trial-subtract the divisor from the shifted remainder
  always_comb begin
    add_x   = {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_y   = {1'b0, operand_q};
    add_sub = 1'b0;
    if (is_div) begin
      add_x   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      add_y   = ~{1'b0, operand_q};
      add_sub = 1'b1;
    end
    // Carry out of bit WIDTH is the "no borrow" flag when subtracting
    add_sum = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+2)'(add_sub);
  end

  // One iteration step of the accumulator
  always_comb begin
    acc_step = '0;
    if (is_div) begin
      if (add_sum[WIDTH+1])
        acc_step = {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0])
        acc_step = {add_sum[WIDTH:0], acc[WIDTH-1:1]};
      else
        acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // Sign correction of the unsigned magnitude result
  always_comb begin
    prod_fix = res_neg ? ((2*WIDTH)'(0) - acc) : acc;
    quot_fix = res_neg ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = rem_neg ? (WIDTH'(0) - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      MDU_IDLE: if (accept) state_next = div_zero ? MDU_FIX : MDU_CALC;
      MDU_CALC: begin
        if (cancel_i)                     state_next = MDU_IDLE;
        else if (cnt == CW'(WIDTH - 1))   state_next = MDU_FIX;
      end
      MDU_FIX:  state_next = cancel_i ? MDU_IDLE : MDU_DONE;
      MDU_DONE: state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
  end

  // FSM outputs: stall from the accepting cycle until the result is in DONE
  always_comb begin
    stallreq_o = accept || (state == MDU_CALC) || (state == MDU_FIX);
  end

  // Datapath registers: operand latch, iteration, result capture and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      operand_q <= '0;
      acc       <= '0;
      is_div    <= 1'b0;
      res_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
      done_o    <= 1'b0;
    end else begin
      done_o <= (state == MDU_FIX) && !cancel_i;
      case (state)
        MDU_IDLE: begin
          if (accept) begin
            is_div <= op_div;
            cnt    <= '0;
            if (div_zero) begin
              // Forced result passes through FIX untouched
              operand_q <= '0;
              acc       <= {opa_i, {WIDTH{1'b1}}};
              res_neg   <= 1'b0;
              rem_neg   <= 1'b0;
            end else begin
              operand_q <= op_div ? b_abs : a_abs;
              acc       <= {{WIDTH{1'b0}}, (op_div ? a_abs : b_abs)};
              res_neg   <= a_sign ^ b_sign;
              rem_neg   <= a_sign;
            end
          end
        end
        MDU_CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        MDU_FIX: begin
          if (!cancel_i) begin
            if (is_div) begin
              hi_o <= rem_fix;
              lo_o <= quot_fix;
            end else begin
              hi_o <= prod_fix[2*WIDTH-1:WIDTH];
              lo_o <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  Mdu_op_t       op_i = MDU_MULT;
  logic [W-1:0]  opa_i = '0;
  logic [W-1:0]  opb_i = '0;
  logic          cancel_i = 1'b0;
  logic          stallreq_o;
  logic          done_o;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    Mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .cancel_i   (cancel_i),
    .stallreq_o (stallreq_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h_%h expected=no_done", hi_o, lo_o);
      end else begin
        chk("result", {hi_o, lo_o}, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input Mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int lat);
    int cyc;
    int stalls;
    @(negedge clk);
    op_i = op; opa_i = a; opb_i = b; start_i = 1'b1;
    #1;
    chk("accept_stall", stallreq_o, 1);
    exp_q.push_back({hi, lo});
    @(negedge clk);
    start_i = 1'b0;
    opa_i = $urandom;
    opb_i = $urandom;
    cyc = 0;
    stalls = 0;
    while (!done_o && cyc < 100) begin
      if (stallreq_o) stalls++;
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("stall_cycles", stalls, lat);
    chk("done_stall_low", stallreq_o, 0);
    @(negedge clk);
    chk("done_pulse", done_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int extra;
    vecs[0]  = '{MDU_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 33};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[4]  = '{MDU_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1};
    vecs[5]  = '{MDU_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 33};
    vecs[6]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[7]  = '{MDU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1};
    vecs[8]  = '{MDU_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 33};
    vecs[9]  = '{MDU_MULT,  32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, 33};
    vecs[10] = '{MDU_DIVU,  32'd5,        32'd9,        32'h00000005, 32'h00000000, 33};
    vecs[11] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[12] = '{MDU_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33};
    vecs[13] = '{MDU_MULTU, 32'd3,        32'd5,        32'h00000000, 32'h0000000F, 33};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_done", done_o, 0);
    chk("reset_stall", stallreq_o, 0);
    chk("reset_hilo", {hi_o, lo_o}, 64'h0);

    // Cancel together with start in IDLE: request not accepted
    @(negedge clk);
    op_i = MDU_MULTU; opa_i = 32'd9; opb_i = 32'd9; start_i = 1'b1; cancel_i = 1'b1;
    #1;
    chk("idle_cancel_stall", stallreq_o, 0);
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    chk("idle_cancel_not_accepted", stallreq_o, 0);

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);

    // Cancel a DIVU in CALC on E10: unit returns to IDLE, outputs keep 0/15
    op_i = MDU_DIVU; opa_i = 32'd100; opb_i = 32'd7; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("calc_stall_before_cancel", stallreq_o, 1);
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    chk("cancel_idle_stall", stallreq_o, 0);
    chk("cancel_no_done", done_o, 0);
    chk("cancel_hilo_kept", {hi_o, lo_o}, {32'd0, 32'd15});
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o || stallreq_o) extra++;
    end
    chk("cancel_quiet", extra, 0);

    // start_i held through DONE: exactly one operation
    op_i = MDU_DIVU; opa_i = 32'd100; opb_i = 32'd7; start_i = 1'b1;
    exp_q.push_back({32'd2, 32'd14});
    @(negedge clk);
    cyc = 0;
    while (!done_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_latency", cyc, 33);
    start_i = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o || stallreq_o) extra++;
    end
    chk("held_single_op", extra, 0);

    // Reset mid-CALC
    op_i = MDU_MULT; opa_i = 32'h12345678; opb_i = 32'h9ABCDEF0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_done", done_o, 0);
    chk("midrst_stall", stallreq_o, 0);
    chk("midrst_hilo", {hi_o, lo_o}, 64'h0);
    run_op(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
